counter_input_conditioner: RTL and testbench

COUNTER_INPUT_CONDITIONER -- requirements
Module: counter_input_conditioner

---
 rtl/counter_input_conditioner.sv | 141 ++++++++++++++
 tb/tb_counter_input_conditioner.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/counter_input_conditioner.sv
// Conditions three raw front-panel inputs (step, load, direction) into clean
// strobes and a level for a downstream up/down counter, with step auto-repeat.
module counter_input_conditioner #(
   parameter int DB_LIMIT     = 16,
   parameter int HOLD_LIMIT   = 500,
   parameter int REPEAT_LIMIT = 100
) (
   input  logic Clock,
   input  logic Reset,
   input  logic StepBtn,
   input  logic LoadBtn,
   input  logic DirSw,
   output logic Step,
   output logic Load,
   output logic Count
);
   localparam int NCH     = 3;
   localparam int STEP_CH = 0;
   localparam int LOAD_CH = 1;
   localparam int DIR_CH  = 2;

   localparam logic [7:0]  DB_LAST   = 8'(DB_LIMIT - 1);
   // The hold window counts cycles after the first Step cycle, so the
   // comparison runs one count further than the repeat interval.
   localparam logic [15:0] HOLD_LAST = 16'(HOLD_LIMIT);
   localparam logic [15:0] REP_LAST  = 16'(REPEAT_LIMIT - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD   = 2'd1,
      REPEAT = 2'd2
   } state_t;

   logic [NCH-1:0]      raw, sync1, sync2, deb;
   logic [NCH-1:0][7:0] dbcnt;
   logic [1:0]          deb_q;
   state_t              state, state_n;
   logic [15:0]         t, t_n;
   logic                emit, step_rise, load_rise, inhibit;

   assign raw = {DirSw, LoadBtn, StepBtn};

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   // Any return of s to d before the count expires restarts the window.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         deb   <= '0;
         dbcnt <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (sync2[i] == deb[i]) begin
               dbcnt[i] <= '0;
            end else if (dbcnt[i] == DB_LAST) begin
               deb[i]   <= sync2[i];
               dbcnt[i] <= '0;
            end else begin
               dbcnt[i] <= dbcnt[i] + 8'd1;
            end
         end
      end
   end

   assign step_rise = deb[STEP_CH] & ~deb_q[STEP_CH];
   assign load_rise = deb[LOAD_CH] & ~deb_q[LOAD_CH];
   // Load owns the counter while its button is down and during its pulse.
   assign inhibit   = deb[LOAD_CH] | Load;
   assign Count     = deb[DIR_CH];

   always_comb begin
      state_n = state;
      t_n     = t;
      emit    = 1'b0;
      if (inhibit) begin
         state_n = IDLE;
         t_n     = '0;
      end else begin
         case (state)
            IDLE: begin
               if (step_rise) begin
                  emit    = 1'b1;
                  t_n     = '0;
                  state_n = HOLD;
               end
            end
            HOLD: begin
               if (!deb[STEP_CH]) begin
                  state_n = IDLE;
                  t_n     = '0;
               end else if (t == HOLD_LAST) begin
                  emit    = 1'b1;
                  t_n     = '0;
                  state_n = REPEAT;
               end else begin
                  t_n = t + 16'd1;
               end
            end
            REPEAT: begin
               if (!deb[STEP_CH]) begin
                  state_n = IDLE;
                  t_n     = '0;
               end else if (t == REP_LAST) begin
                  emit = 1'b1;
                  t_n  = '0;
               end else begin
                  t_n = t + 16'd1;
               end
            end
            default: begin
               state_n = IDLE;
               t_n     = '0;
            end
         endcase
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state <= IDLE;
         t     <= '0;
         deb_q <= '0;
         Step  <= 1'b0;
         Load  <= 1'b0;
      end else begin
         state <= state_n;
         t     <= t_n;
         deb_q <= deb[1:0];
         Step  <= emit;
         Load  <= load_rise;
      end
   end

endmodule

// File: tb/tb_counter_input_conditioner.sv
// Directed bench for counter_input_conditioner with DB_LIMIT=4, HOLD_LIMIT=10,
// REPEAT_LIMIT=3; vector n's expectations describe outputs after edge n.
module tb_counter_input_conditioner;
   localparam int DBL = 4;
   localparam int HL  = 10;
   localparam int RL  = 3;

   logic Clock   = 1'b0;
   logic Reset   = 1'b0;
   logic StepBtn = 1'b0;
   logic LoadBtn = 1'b0;
   logic DirSw   = 1'b0;
   logic Step, Load, Count;

   int errors = 0;
   int checks = 0;

   typedef struct {
      bit rst;
      bit sb, lb, ds;
      bit es, el, ec;
   } vec_t;
   vec_t tbl[$];

   counter_input_conditioner #(
      .DB_LIMIT(DBL), .HOLD_LIMIT(HL), .REPEAT_LIMIT(RL)
   ) u_dut (
      .Clock(Clock), .Reset(Reset),
      .StepBtn(StepBtn), .LoadBtn(LoadBtn), .DirSw(DirSw),
      .Step(Step), .Load(Load), .Count(Count)
   );

   always #5 Clock = ~Clock;

   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic do_reset();
      Reset = 1'b0; StepBtn = 1'b0; LoadBtn = 1'b0; DirSw = 1'b0;
      repeat (2) tick();
      Reset = 1'b1;
   endtask

   task automatic add(input bit r, input bit sb, input bit lb, input bit ds,
                      input bit es, input bit el, input bit ec);
      vec_t v;
      v.rst = r; v.sb = sb; v.lb = lb; v.ds = ds;
      v.es = es; v.el = el; v.ec = ec;
      tbl.push_back(v);
   endtask

   initial begin
      // clean step press held 8 cycles: one Step after edge 6
      for (int i = 0; i < 14; i++) add(i == 0, i < 8, 0, 0, i == 6, 0, 0);
      // bounce 1,0,1,0 then steady: single Step after edge 10
      for (int i = 0; i < 16; i++)
         add(i == 0, (i == 0) || (i == 2) || (i >= 4), 0, 0, i == 10, 0, 0);
      // direction switch: Count from edge 5
      for (int i = 0; i < 8; i++) add(i == 0, 0, 0, 1, 0, 0, i >= 5);
      // 2-cycle direction glitch is filtered
      for (int i = 0; i < 10; i++) add(i == 0, 0, 0, i < 2, 0, 0, 0);
      // load press held 8 cycles: one Load after edge 6, none on release
      for (int i = 0; i < 16; i++) add(i == 0, 0, i < 8, 0, 0, i == 6, 0);

      // reset state
      #2;
      chk("rst_step", Step, 1'b0);
      chk("rst_load", Load, 1'b0);
      chk("rst_count", Count, 1'b0);

      begin
         int cyc;
         cyc = 0;
         foreach (tbl[n]) begin
            if (tbl[n].rst) begin
               do_reset();
               cyc = 0;
            end
            StepBtn = tbl[n].sb; LoadBtn = tbl[n].lb; DirSw = tbl[n].ds;
            tick();
            chk($sformatf("vec%0d/e%0d step", n, cyc), Step, tbl[n].es);
            chk($sformatf("vec%0d/e%0d load", n, cyc), Load, tbl[n].el);
            chk($sformatf("vec%0d/e%0d count", n, cyc), Count, tbl[n].ec);
            cyc++;
         end
      end

      // long hold: 6, 17, then every 3 until release debounces
      do_reset();
      for (int c = 0; c < 60; c++) begin
         StepBtn = (c < 40);
         tick();
         chk($sformatf("hold e%0d step", c), Step,
             (c == 6) || (c == 17) || (c >= 20 && c <= 44 && (c - 20) % 3 == 0));
      end

      // load pressed while stepping is in REPEAT
      do_reset();
      StepBtn = 1'b1;
      for (int c = 0; c < 22; c++) begin
         tick();
         chk($sformatf("pre_load e%0d step", c), Step, (c == 6) || (c == 17) || (c == 20));
      end
      for (int r = 0; r < 58; r++) begin
         LoadBtn = (r < 10);
         StepBtn = (r < 41) || (r >= 50);
         tick();
         chk($sformatf("ld r%0d step", r), Step, (r == 1) || (r == 4) || (r == 56));
         chk($sformatf("ld r%0d load", r), Load, r == 6);
         if (Step === 1'b1 && Load === 1'b1) chk("ld overlap", 1'b1, 1'b0);
      end

      // reset mid-repeat with buttons still high
      do_reset();
      StepBtn = 1'b1; DirSw = 1'b1;
      for (int c = 0; c <= 20; c++) tick();
      chk("pre_rst step", Step, 1'b1);
      chk("pre_rst count", Count, 1'b1);
      #2 Reset = 1'b0;
      #1;
      chk("async_rst step", Step, 1'b0);
      chk("async_rst load", Load, 1'b0);
      chk("async_rst count", Count, 1'b0);
      repeat (2) begin
         tick();
         chk("in_rst step", Step, 1'b0);
         chk("in_rst count", Count, 1'b0);
      end
      Reset = 1'b1;
      for (int r = 0; r < 22; r++) begin
         tick();
         chk($sformatf("post_rst r%0d step", r), Step, (r == 6) || (r == 17) || (r == 20));
         chk($sformatf("post_rst r%0d load", r), Load, 1'b0);
         chk($sformatf("post_rst r%0d count", r), Count, r >= 5);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
